// File: rtl/uart_tx_wb.sv
// Wishbone-attached UART transmitter: CSR block, TX FIFO and an 8N1/8N2 serialiser.
// Frames start from the FIFO head and run back-to-back while tx_en is set.
module uart_tx_wb #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd867
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   output logic        wb_ack_o,
   output logic        o_uart_tx,
   output logic        o_tx_irq
);
   localparam int            PW       = $clog2(FIFO_DEPTH);
   localparam int            CW       = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   // Bus / CSR state
   logic          ack_q;
   logic [31:0]   dat_q;
   logic [15:0]   div_q;
   logic          tx_en_q, two_stop_q, irq_en_q, ovf_q, irq_q;

   // FIFO state
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;

   // Serialiser state
   state_e        state_q, state_d;
   logic [15:0]   cnt_q, cnt_d, fdiv_q, fdiv_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          ftwo_q, ftwo_d;
   logic          tx_q;

   logic          req, wr_en, push_req, push, pop, ovf_set, ovf_clr;
   logic          full, empty, busy, bit_end, start_ok;
   logic [1:0]    addr;
   logic [7:0]    head;
   logic [31:0]   rd_data;
   logic          unused_bits;

   assign unused_bits = ^{wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:16]};

   assign addr     = wb_adr_i[3:2];
   assign req      = wb_stb_i & wb_cyc_i & ~ack_q;
   assign wr_en    = req & wb_we_i & wb_sel_i[0];
   assign push_req = wr_en & (addr == 2'd0);
   assign ovf_clr  = wr_en & (addr == 2'd3) & wb_dat_i[3];

   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign busy     = (state_q != S_IDLE);
   assign head     = mem[rd_ptr_q];

   // A full FIFO still takes the write when the serialiser frees a slot on the same edge.
   assign push     = push_req & (~full | pop);
   assign ovf_set  = push_req & full & ~pop;

   always_comb begin
      rd_data = '0;
      if (req && !wb_we_i) begin
         case (addr)
            2'd1:    rd_data = {23'd0, 5'(count_q), ovf_q, empty, full, busy};
            2'd2:    rd_data = {16'd0, div_q};
            2'd3:    rd_data = {29'd0, irq_en_q, two_stop_q, tx_en_q};
            default: rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ack_q      <= 1'b0;
         dat_q      <= '0;
         div_q      <= DIV_RESET;
         tx_en_q    <= 1'b0;
         two_stop_q <= 1'b0;
         irq_en_q   <= 1'b0;
         ovf_q      <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         ack_q <= req;
         dat_q <= rd_data;
         if (wr_en && addr == 2'd2) div_q <= wb_dat_i[15:0];
         if (wr_en && addr == 2'd3) begin
            tx_en_q    <= wb_dat_i[0];
            two_stop_q <= wb_dat_i[1];
            irq_en_q   <= wb_dat_i[2];
         end
         if (ovf_set)      ovf_q <= 1'b1;
         else if (ovf_clr) ovf_q <= 1'b0;
         irq_q <= empty & irq_en_q;
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
      end
   end

   // NOTE: storage is left unreset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= wb_dat_i[7:0];
   end

   assign bit_end  = (cnt_q == '0);
   assign start_ok = tx_en_q & ~empty;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      fdiv_d  = fdiv_q;
      ftwo_d  = ftwo_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               pop     = 1'b1;
               state_d = S_START;
               shift_d = head;
               fdiv_d  = div_q;
               ftwo_d  = two_stop_q;
               cnt_d   = div_q;
               idx_d   = '0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               cnt_d   = fdiv_q;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d   = fdiv_q;
               shift_d = {1'b0, shift_q[7:1]};
               if (idx_q == 3'd7) begin
                  state_d = S_STOP;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_STOP: begin
            if (!bit_end) begin
               cnt_d = cnt_q - 16'd1;
            end else if (ftwo_q && idx_q == 3'd0) begin
               idx_d = 3'd1;
               cnt_d = fdiv_q;
            end else if (start_ok) begin
               pop     = 1'b1;
               state_d = S_START;
               shift_d = head;
               fdiv_d  = div_q;
               ftwo_d  = two_stop_q;
               cnt_d   = div_q;
               idx_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         fdiv_q  <= '0;
         ftwo_q  <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         fdiv_q  <= fdiv_d;
         ftwo_q  <= ftwo_d;
         // The line is a registered image of the current state, one cycle behind it.
         case (state_q)
            S_START: tx_q <= 1'b0;
            S_DATA:  tx_q <= shift_q[0];
            default: tx_q <= 1'b1;
         endcase
      end
   end

   assign wb_ack_o  = ack_q;
   assign wb_dat_o  = dat_q;
   assign o_uart_tx = tx_q;
   assign o_tx_irq  = irq_q;

endmodule

// File: tb/tb_uart_tx_wb.sv
// Bench for uart_tx_wb: bus driver feeds a byte scoreboard, an independent serial
// receiver decodes o_uart_tx and checks each frame against it.
module tb_uart_tx_wb;
   localparam int          DEPTH   = 8;
   localparam logic [15:0] DIV_RST = 16'd867;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o;
   logic        o_uart_tx, o_tx_irq;

   uart_tx_wb #(.FIFO_DEPTH(DEPTH), .DIV_RESET(DIV_RST)) dut (
      .clk(clk), .reset(reset),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i),
      .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
      .o_uart_tx(o_uart_tx), .o_tx_irq(o_tx_irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_q[$];
   int         start_cyc_q[$];
   int         cur_div = 0;
   bit         cur_two = 1'b0;
   int         last_ack_cyc = 0;

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
      end
   endtask

   function automatic logic [31:0] status_word(input bit busy, input int count, input bit ovf);
      return {23'd0, 5'(count), ovf, count == 0, count == DEPTH, busy};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] d,
                          input logic [3:0] sel, output logic [31:0] rd);
      int n = 0;
      wb_adr_i = {a, 2'b00};
      wb_dat_i = d;
      wb_sel_i = sel;
      wb_we_i  = we;
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      do begin
         tick();
         n++;
      end while (!wb_ack_o && n < 8);
      if (!wb_ack_o) check(1'b0, "ack_timeout", 32'(n), 32'd2);
      rd           = wb_dat_o;
      last_ack_cyc = cyc;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      wb_xfer(1'b1, a, d, 4'hF, dummy);
   endtask

   task automatic wb_write_sel(input logic [1:0] a, input logic [31:0] d, input logic [3:0] sel);
      logic [31:0] dummy;
      wb_xfer(1'b1, a, d, sel, dummy);
   endtask

   task automatic read_check(input logic [1:0] a, input logic [31:0] exp_v, input string name);
      logic [31:0] rd;
      wb_xfer(1'b0, a, 32'd0, 4'hF, rd);
      check(rd === exp_v, name, rd, exp_v);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check(exp_q.size() == 0, "drain_timeout", 32'(exp_q.size()), 32'd0);
      repeat (2) tick();
   endtask

   task automatic wait_starts(input int want, input int budget);
      int n = 0;
      while (start_cyc_q.size() < want && n < budget) begin
         tick();
         n++;
      end
      check(start_cyc_q.size() >= want, "start_timeout", 32'(start_cyc_q.size()), 32'(want));
   endtask

   function automatic int start_gap(input int first);
      if (start_cyc_q.size() < first + 2) return -1;
      return start_cyc_q[first+1] - start_cyc_q[first];
   endfunction

   // Serial receiver: bit width comes from the configured divisor, frames are
   // compared against the scoreboard in the order bytes were accepted.
   initial begin : monitor
      logic        prev;
      int          d;
      bit          two, stable, aborted;
      int          nb;
      logic [10:0] bits, exp_bits;
      logic [7:0]  e;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev = 1'b1;
         end else if (prev && !o_uart_tx) begin
            d       = cur_div;
            two     = cur_two;
            nb      = two ? 11 : 10;
            bits    = '1;
            stable  = 1'b1;
            aborted = 1'b0;
            start_cyc_q.push_back(cyc);
            for (int b = 0; b < nb && !aborted; b++) begin
               for (int c = 0; c <= d && !aborted; c++) begin
                  if (b != 0 || c != 0) @(negedge clk);
                  if (reset)                    aborted = 1'b1;
                  else if (c == 0)              bits[b] = o_uart_tx;
                  else if (o_uart_tx !== bits[b]) stable = 1'b0;
               end
            end
            if (aborted) begin
               prev = 1'b1;
            end else begin
               check(stable, "bit_width", 32'(bits), 32'(d + 1));
               check(exp_q.size() > 0, "frame_expected", 32'(exp_q.size()), 32'd1);
               if (exp_q.size() > 0) begin
                  e        = exp_q.pop_front();
                  exp_bits = {2'b11, e, 1'b0};
                  check(bits === exp_bits, "frame_bits", 32'(bits), 32'(exp_bits));
               end
               prev = o_uart_tx;
            end
         end else begin
            prev = o_uart_tx;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin : stimulus
      int         ns, ack_c, s, cnt, d;
      bit         ovf, t;
      logic [7:0] b;

      reset    = 1'b1;
      wb_adr_i = '0;
      wb_dat_i = '0;
      wb_sel_i = '0;
      wb_we_i  = 1'b0;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      check(o_uart_tx === 1'b1, "reset_tx", 32'(o_uart_tx), 32'd1);
      check(wb_ack_o === 1'b0, "reset_ack", 32'(wb_ack_o), 32'd0);
      check(wb_dat_o === 32'd0, "reset_dat", wb_dat_o, 32'd0);
      check(o_tx_irq === 1'b0, "reset_irq", 32'(o_tx_irq), 32'd0);
      read_check(2'd1, status_word(0, 0, 0), "reset_status");
      read_check(2'd2, 32'(DIV_RST), "reset_div");
      read_check(2'd3, 32'd0, "reset_ctrl");
      read_check(2'd0, 32'd0, "txdata_reads_zero");

      // 0x55 at DIV=3: start latency, busy mid-frame, empty afterwards
      wb_write(2'd2, 32'd3);
      cur_div = 3;
      cur_two = 1'b0;
      wb_write(2'd3, 32'd1);
      ns = start_cyc_q.size();
      exp_q.push_back(8'h55);
      wb_write(2'd0, 32'h55);
      ack_c = last_ack_cyc;
      wait_starts(ns + 1, 20);
      check(start_cyc_q.size() > ns && start_cyc_q[ns] - ack_c == 2, "start_latency",
            32'(start_cyc_q.size() > ns ? start_cyc_q[ns] - ack_c : -1), 32'd2);
      repeat (10) tick();
      read_check(2'd1, status_word(1, 0, 0), "busy_mid_frame");
      wait_drain(200);
      read_check(2'd1, status_word(0, 0, 0), "idle_after_frame");

      // Back-to-back frames at DIV=1
      wb_write(2'd2, 32'd1);
      cur_div = 1;
      ns = start_cyc_q.size();
      exp_q.push_back(8'hA3);
      exp_q.push_back(8'h0F);
      wb_write(2'd0, 32'hA3);
      wb_write(2'd0, 32'h0F);
      wait_drain(200);
      check(start_gap(ns) == 20, "back_to_back_gap", 32'(start_gap(ns)), 32'd20);

      // Overflow with the serialiser disabled
      wb_write(2'd3, 32'd0);
      cnt = 0;
      ovf = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         b = 8'($urandom);
         wb_write(2'd0, 32'(b));
         if (cnt < DEPTH) begin
            exp_q.push_back(b);
            cnt++;
         end else begin
            ovf = 1'b1;
         end
      end
      read_check(2'd1, status_word(0, cnt, ovf), "status_full_ovf");
      wb_write(2'd3, 32'h8);
      read_check(2'd1, status_word(0, cnt, 0), "status_ovf_cleared");
      read_check(2'd3, 32'd0, "ctrl_w1c_reads_zero");
      wb_write(2'd3, 32'd1);
      wait_drain(DEPTH * 20 + 60);
      read_check(2'd1, status_word(0, 0, 0), "status_after_drain");

      // Two stop bits at DIV=2
      wb_write(2'd2, 32'd2);
      cur_div = 2;
      cur_two = 1'b1;
      wb_write(2'd3, 32'd3);
      ns = start_cyc_q.size();
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      wb_write(2'd0, 32'hFF);
      wb_write(2'd0, 32'h00);
      wait_drain(200);
      check(start_gap(ns) == 33, "two_stop_gap", 32'(start_gap(ns)), 32'd33);

      // Reset during data bit 3 of 0xA5 (bit 3 is 0), with a second byte queued
      wb_write(2'd2, 32'd3);
      cur_div = 3;
      cur_two = 1'b0;
      wb_write(2'd3, 32'd1);
      ns = start_cyc_q.size();
      wb_write(2'd0, 32'hA5);
      wb_write(2'd0, 32'h11);
      wait_starts(ns + 1, 40);
      s = (start_cyc_q.size() > ns) ? start_cyc_q[ns] : cyc;
      while (cyc < s + 16) tick();
      reset = 1'b1;
      @(negedge clk);
      check(o_uart_tx === 1'b0, "line_at_bit3", 32'(o_uart_tx), 32'd0);
      @(negedge clk);
      check(o_uart_tx === 1'b1, "line_after_reset", 32'(o_uart_tx), 32'd1);
      tick();
      reset = 1'b0;
      read_check(2'd1, status_word(0, 0, 0), "status_after_reset");
      read_check(2'd2, 32'(DIV_RST), "div_after_reset");
      read_check(2'd3, 32'd0, "ctrl_after_reset");
      wb_write_sel(2'd0, 32'h77, 4'b1110);
      read_check(2'd1, status_word(0, 0, 0), "push_needs_lane0");
      wb_write_sel(2'd2, 32'd5, 4'b1110);
      read_check(2'd2, 32'(DIV_RST), "div_needs_lane0");
      wb_write(2'd2, 32'd1);
      cur_div = 1;
      wb_write(2'd3, 32'd1);
      repeat (60) tick();
      check(start_cyc_q.size() == ns + 1, "fifo_discarded", 32'(start_cyc_q.size()), 32'(ns + 1));

      // Interrupt follows empty & irq_en one cycle late
      wb_write(2'd3, 32'h4);
      repeat (2) tick();
      check(o_tx_irq === 1'b1, "irq_when_empty", 32'(o_tx_irq), 32'd1);
      exp_q.push_back(8'h3C);
      wb_write(2'd0, 32'h3C);
      check(o_tx_irq === 1'b1, "irq_latency", 32'(o_tx_irq), 32'd1);
      tick();
      check(o_tx_irq === 1'b0, "irq_drop_after_push", 32'(o_tx_irq), 32'd0);
      exp_q.push_back(8'hC3);
      wb_write(2'd0, 32'hC3);
      wb_write(2'd3, 32'h5);
      wait_drain(200);
      check(o_tx_irq === 1'b1, "irq_after_last_pop", 32'(o_tx_irq), 32'd1);

      // Randomised configurations and byte streams
      for (int k = 0; k < 4; k++) begin
         d = int'($urandom_range(0, 3));
         t = 1'($urandom_range(0, 1));
         wb_write(2'd2, 32'(d));
         cur_div = d;
         cur_two = t;
         wb_write(2'd3, 32'(1 | (int'(t) << 1)));
         for (int i = 0; i < 10; i++) begin
            for (int w = 0; w < 400 && exp_q.size() >= DEPTH; w++) tick();
            b = 8'($urandom);
            exp_q.push_back(b);
            wb_write(2'd0, 32'(b));
            repeat ($urandom_range(0, 25)) tick();
         end
         wait_drain(DEPTH * 44 + 100);
      end
      read_check(2'd1, status_word(0, 0, 0), "final_status");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
